// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   PC_W_DEFAULT : default PC / instruction-memory address width
//   OPC_*        : 3-bit opcodes carried in instruction bits [15:13]
//   fetch_state_t: fetch-stage FSM encoding
package cpu_pkg;

    localparam int PC_W_DEFAULT = 9;

    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
//   clk, reset : clock, synchronous active-high reset (loads RESET_PC)
//   load       : load load_pc (redirect); takes priority over inc
//   load_pc    : redirect target
//   inc        : advance by one, wrapping modulo 2^PC_W
//   pc         : current program counter
module pc_counter #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            // Natural PC_W-bit overflow gives the required wrap to zero.
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : downstream cannot accept; hold the output buffer
//   redirect_valid/_pc  : flush and restart fetch at redirect_pc
//   mem_req/mem_addr    : instruction read request (addr = pc while req=1)
//   mem_ack/mem_rdata   : read response, honoured only while mem_req=1
//   instr_valid/instr/instr_pc : one-entry output buffer to decode
//   halted              : a HALT opcode was fetched; fetching stopped
//   dbg_state           : current FSM state, for observation only
//
// Handshakes: a memory read completes in a cycle where mem_req=1 and
// mem_ack=1 (ack may arrive in the same cycle as req). Once raised, req and
// addr hold until ack, redirect or reset; a dropped request owes no ack.
// Decode consumes the buffer in a cycle where instr_valid=1 and stall=0.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic            instr_valid,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            halted,
    output fetch_state_t    dbg_state
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc;
    logic            buf_free;
    logic            accept;
    logic            is_halt;

    pc_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (accept),
        .pc      (pc)
    );

    // The buffer can take a new word if it is empty or being consumed now.
    assign buf_free = !instr_valid || !stall;
    // Redirect forces the request low so a same-cycle ack is discarded.
    assign mem_req  = (state == FETCH) && buf_free && !redirect_valid;
    assign mem_addr = pc;
    assign accept   = mem_req && mem_ack;
    assign is_halt  = (mem_rdata[15:13] == OPC_HALT);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (accept && is_halt) state_next = HALT;
            HALT:  state_next = HALT;
            default: state_next = IDLE;
        endcase
        if (redirect_valid) begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (accept) begin
            instr_valid <= 1'b1;
            instr       <= mem_rdata;
            instr_pc    <= pc;
            if (is_halt) begin
                halted <= 1'b1;
            end
        end else if (instr_valid && !stall) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            stall = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [15:0]     mem_rdata;
    logic            instr_valid;
    logic [15:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            halted;
    fetch_state_t    dbg_state;

    int errors = 0;
    int checks = 0;

    // Memory model: ack after `lat` waiting cycles; force_ack injects a stray ack.
    logic [15:0] mem [0:511];
    int          lat = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;

    assign mem_ack   = (mem_req && (wait_cnt == lat)) || force_ack;
    assign mem_rdata = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0]     = 16'hD001;
        mem[1]     = 16'hD102;
        mem[2]     = 16'hD203;
        mem[3]     = 16'hE000;
        mem[5]     = 16'hA555;
        mem[9'h010] = 16'h6010;
        mem[9'h040] = 16'hB040;
        mem[9'h1FF] = 16'h21FF;

        // Reset and the bubble cycle
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_pc", 32'(instr_pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("bubble_req", 32'(mem_req), 0);

        // Zero-wait streaming up to HALT
        tick(); #1;
        check("t1_req0", 32'(mem_req), 1);
        check("t1_addr0", 32'(mem_addr), 0);
        tick(); #1;
        check("t1_i0", 32'(instr), 'hD001);
        check("t1_p0", 32'(instr_pc), 0);
        check("t1_v0", 32'(instr_valid), 1);
        tick(); #1;
        check("t1_i1", 32'(instr), 'hD102);
        check("t1_p1", 32'(instr_pc), 1);
        tick(); #1;
        check("t1_i2", 32'(instr), 'hD203);
        check("t1_p2", 32'(instr_pc), 2);
        tick(); #1;
        check("t1_i3", 32'(instr), 'hE000);
        check("t1_p3", 32'(instr_pc), 3);
        check("t1_halted", 32'(halted), 1);
        check("t1_req_halt", 32'(mem_req), 0);
        tick(); #1;
        check("t1_drain", 32'(instr_valid), 0);
        check("t1_req_after", 32'(mem_req), 0);
        check("t1_state", 32'(dbg_state), 32'(HALT));

        // Stray ack while halted with req=0 must be ignored
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        #1;
        check("stray_ack", 32'(instr_valid), 0);

        // 2-cycle latency: redirect to 0 out of HALT
        lat = 2;
        redirect_valid = 1'b1;
        redirect_pc = 9'h000;
        #1;
        check("t2_redir_req", 32'(mem_req), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t2_unhalt", 32'(halted), 0);
        for (int cyc = 0; cyc <= 9; cyc++) begin
            if (cyc > 0) begin
                tick(); #1;
            end
            check($sformatf("t2_req_c%0d", cyc), 32'(mem_req), 1);
            check($sformatf("t2_addr_c%0d", cyc), 32'(mem_addr), 32'(cyc / 3));
            check($sformatf("t2_valid_c%0d", cyc), 32'(instr_valid),
                  (cyc > 0 && cyc % 3 == 0) ? 1 : 0);
            if (cyc > 0 && cyc % 3 == 0)
                check($sformatf("t2_pc_c%0d", cyc), 32'(instr_pc), 32'(cyc / 3 - 1));
        end

        // Stall hold: redirect to 0 at zero-wait, stall on D102/pc1
        lat = 0;
        redirect_valid = 1'b1;
        redirect_pc = 9'h000;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            #1;
            check($sformatf("t3_instr_%0d", k), 32'(instr), 'hD102);
            check($sformatf("t3_pc_%0d", k), 32'(instr_pc), 1);
            check($sformatf("t3_valid_%0d", k), 32'(instr_valid), 1);
            check($sformatf("t3_req_%0d", k), 32'(mem_req), 0);
        end
        tick();
        stall = 1'b0;
        #1;
        check("t3_consume_req", 32'(mem_req), 1);
        check("t3_consume_addr", 32'(mem_addr), 2);
        check("t3_consume_pc", 32'(instr_pc), 1);
        tick(); #1;
        check("t3_next_instr", 32'(instr), 'hD203);
        check("t3_next_pc", 32'(instr_pc), 2);

        // Redirect colliding with an ack: fetch pc 5, redirect to 0x040
        lat = 2;
        redirect_valid = 1'b1;
        redirect_pc = 9'h005;
        #1;
        check("t4_redir_req", 32'(mem_req), 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_addr5", 32'(mem_addr), 5);
        check("t4_flushed", 32'(instr_valid), 0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 9'h040;
        force_ack = 1'b1;
        #1;
        check("t4_req_drop", 32'(mem_req), 0);
        tick();
        redirect_valid = 1'b0;
        force_ack = 1'b0;
        lat = 0;
        #1;
        check("t4_discard", 32'(instr_valid), 0);
        check("t4_addr40", 32'(mem_addr), 'h040);
        tick(); #1;
        check("t4_pc40", 32'(instr_pc), 'h040);
        check("t4_instr40", 32'(instr), 'hB040);

        // PC wrap at 0x1FF
        redirect_valid = 1'b1;
        redirect_pc = 9'h1FF;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_addr1ff", 32'(mem_addr), 'h1FF);
        tick(); #1;
        check("t5_pc1ff", 32'(instr_pc), 'h1FF);
        check("t5_instr1ff", 32'(instr), 'h21FF);
        check("t5_wrap_addr", 32'(mem_addr), 0);

        // Run on to HALT (bounded), then redirect out of it
        for (int k = 0; k < 10 && !halted; k++) tick();
        #1;
        check("t6_halted", 32'(halted), 1);
        tick(); #1;
        check("t6_req_halted", 32'(mem_req), 0);
        redirect_valid = 1'b1;
        redirect_pc = 9'h010;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t6_unhalt", 32'(halted), 0);
        check("t6_addr10", 32'(mem_addr), 'h010);
        tick(); #1;
        check("t6_pc10", 32'(instr_pc), 'h010);
        check("t6_instr10", 32'(instr), 'h6010);

        // Reset in the middle of a wait
        lat = 3;
        tick(); #1;
        check("t7_waiting", 32'(mem_req), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t7_valid", 32'(instr_valid), 0);
        check("t7_instr", 32'(instr), 0);
        check("t7_pc", 32'(instr_pc), 0);
        check("t7_halted", 32'(halted), 0);
        check("t7_req", 32'(mem_req), 0);
        check("t7_addr", 32'(mem_addr), 0);
        check("t7_state", 32'(dbg_state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
